// File: rtl/scan_pkg.sv
// Shared types and helpers for the row-scan sequencer.
// next_enabled_row is only referenced when SCAN_SKIP_MASK_EN is defined.
package scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

  localparam int ROWS  = 8;
  localparam int SEL_W = 3;

  // Returns {found, index}: lowest enabled row above cur, else lowest enabled row overall.
  function automatic logic [SEL_W:0] next_enabled_row(input logic [SEL_W-1:0] cur,
                                                      input logic [ROWS-1:0]  mask);
    logic [SEL_W:0] res;
    logic [31:0]    idx;
    res = {1'b0, 3'd0};
    for (int i = ROWS - 1; i >= 0; i--) begin
      idx = i;
      if (mask[i]) begin
        res = {1'b1, idx[SEL_W-1:0]};
      end
    end
    for (int i = ROWS - 1; i >= 0; i--) begin
      idx = i;
      if (mask[i] && (i > int'(cur))) begin
        res = {1'b1, idx[SEL_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter timing the dwell on each row; expire flags a count of zero.
module scan_dwell_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  input  logic             en,
  output logic             expire
);

  logic [DIV_W-1:0] cnt_r;

  // Load has priority over counting down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (load) begin
      cnt_r <= val;
    end else if (en) begin
      cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/row_scan_sequencer.sv
// Row-select sequencer feeding the 3-to-8 decoder; steps rows with a programmable dwell.
// Optional SCAN_SKIP_MASK_EN adds row_mask so disabled rows are skipped.
module row_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             single,
  input  logic [DIV_W-1:0] div,
`ifdef SCAN_SKIP_MASK_EN
  input  logic [ROWS-1:0]  row_mask,
`endif
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic             row_valid,
  output logic             busy,
  output logic             pass_done
);

  scan_state_t      state_r;
  logic [SEL_W-1:0] row_r;
  logic             busy_r;
  logic             pass_done_r;

  logic             expire_s;
  logic             any_en_s;
  logic             wrap_s;
  logic [SEL_W-1:0] next_row_s;
  logic [SEL_W-1:0] first_row_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic             leave_s;
  logic [DIV_W-1:0] cnt_val_s;

`ifdef SCAN_SKIP_MASK_EN
  logic [SEL_W:0] nxt_f_s;
  logic [SEL_W:0] first_f_s;

  // Next/first enabled rows from the live mask; only consumed at dwell end or start.
  always_comb begin
    nxt_f_s     = next_enabled_row(row_r, row_mask);
    first_f_s   = next_enabled_row(3'd7, row_mask);
    any_en_s    = nxt_f_s[SEL_W];
    next_row_s  = nxt_f_s[SEL_W-1:0];
    first_row_s = first_f_s[SEL_W-1:0];
    wrap_s      = (nxt_f_s[SEL_W-1:0] <= row_r);
  end
`else
  // Without a mask every row is visited in order.
  always_comb begin
    any_en_s    = 1'b1;
    next_row_s  = row_r + 3'd1;
    first_row_s = 3'd0;
    wrap_s      = (row_r == 3'd7);
  end
`endif

  // Dwell counter control mirrors the FSM transitions below.
  always_comb begin
    leave_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    if (state_r == RUN) begin
      leave_s    = stop | (expire_s & (~any_en_s | (wrap_s & single)));
      cnt_load_s = stop | expire_s;
      cnt_en_s   = ~stop & ~expire_s;
    end else begin
      cnt_load_s = start & ~stop & any_en_s;
    end
    cnt_val_s = leave_s ? {DIV_W{1'b0}} : div;
  end

  scan_dwell_counter #(.DIV_W(DIV_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load_s),
    .val    (cnt_val_s),
    .en     (cnt_en_s),
    .expire (expire_s)
  );

  // Scan FSM with row register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      row_r       <= 3'd0;
      busy_r      <= 1'b0;
      pass_done_r <= 1'b0;
    end else begin
      pass_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !stop && any_en_s) begin
            state_r <= RUN;
            row_r   <= first_row_s;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            row_r   <= 3'd0;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_r <= IDLE;
            row_r   <= 3'd0;
            busy_r  <= 1'b0;
          end else if (expire_s) begin
            if (!any_en_s) begin
              state_r <= IDLE;
              row_r   <= 3'd0;
              busy_r  <= 1'b0;
            end else if (wrap_s && single) begin
              state_r     <= IDLE;
              row_r       <= 3'd0;
              busy_r      <= 1'b0;
              pass_done_r <= 1'b1;
            end else begin
              row_r       <= next_row_s;
              pass_done_r <= wrap_s;
            end
          end else begin
            row_r <= row_r;
          end
        end
        default: begin
          state_r <= IDLE;
          row_r   <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_a     = row_r[2];
  assign sel_b     = row_r[1];
  assign sel_c     = row_r[0];
  assign row_valid = busy_r;
  assign busy      = busy_r;
  assign pass_done = pass_done_r;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed, table-driven bench for row_scan_sequencer (mask cases need SCAN_SKIP_MASK_EN).
module tb_row_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       single;
  logic [7:0] div;
  logic [7:0] row_mask;
  logic       sel_a, sel_b, sel_c, row_valid, busy, pass_done;

  int n_cmp;
  int n_bad;

  row_scan_sequencer #(.DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .single    (single),
    .div       (div),
`ifdef SCAN_SKIP_MASK_EN
    .row_mask  (row_mask),
`endif
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .sel_c     (sel_c),
    .row_valid (row_valid),
    .busy      (busy),
    .pass_done (pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] div;
    logic [2:0] sel;
    logic       valid;
    logic       pd;
  } vec_t;

  vec_t vecs [12];

  // Expected pattern: {sel[2:0], row_valid, busy, pass_done}
  task automatic check(input string name, input logic [2:0] esel, input logic ev, input logic epd);
    logic [5:0] got;
    logic [5:0] exp;
    got = {sel_a, sel_b, sel_c, row_valid, busy, pass_done};
    exp = {esel, ev, ev, epd};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel/valid/busy/pd=%b required %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    stop = 1'b1; start = 1'b0;
    step();
    stop = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0;
    div = 8'd0; row_mask = 8'hFF;
    #12;
    check("reset", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 3'd0, 1'b0, 1'b0);

    // Test 1: free-running, div=0
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd6, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd7, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      single = vecs[i].single; div = vecs[i].div;
      step();
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].pd);
    end

    // Test 2: single pass, div=3 -> 4 cycles per row, 32 cycles total
    begin
      int pd_cnt;
      logic [2:0] er;
      pd_cnt = 0;
      start = 1'b1; single = 1'b1; div = 8'd3;
      for (int k = 0; k < 32; k++) begin
        step();
        start = 1'b0;
        er = 3'(k / 4);
        if (pass_done) pd_cnt++;
        check($sformatf("single_k%0d", k), er, 1'b1, 1'b0);
      end
      step();
      if (pass_done) pd_cnt++;
      check("single_end", 3'd0, 1'b0, 1'b1);
      step();
      if (pass_done) pd_cnt++;
      check("single_after", 3'd0, 1'b0, 1'b0);
      n_cmp++;
      if (pd_cnt != 1) begin
        n_bad++;
        $display("FAIL single_pd_count: got %0d required 1", pd_cnt);
      end
    end

    // Test 3: stop with start held in row 5
    single = 1'b0; div = 8'd0; start = 1'b1;
    step();
    check("stop_row0", 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step();
    check("stop_row5", 3'd5, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    check("stop_idle", 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stop_hold%0d", k), 3'd0, 1'b0, 1'b0);
    end
    stop = 1'b0; start = 1'b0;
    step();

    // Test 4: async reset mid-dwell of row 3 (div=3)
    div = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) step();
    check("rst_row3", 3'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("rst_stay_idle", 3'd0, 1'b0, 1'b0);

    // Test 5: div 1 -> 4 mid-row
    begin
      logic [2:0] exp5 [8];
      exp5[0] = 3'd0; exp5[1] = 3'd0; exp5[2] = 3'd1; exp5[3] = 3'd1;
      exp5[4] = 3'd1; exp5[5] = 3'd1; exp5[6] = 3'd1; exp5[7] = 3'd2;
      div = 8'd1; start = 1'b1;
      for (int k = 0; k < 8; k++) begin
        step();
        start = 1'b0; div = 8'd4;
        check($sformatf("divchg_k%0d", k), exp5[k], 1'b1, 1'b0);
      end
      go_idle();
    end

`ifdef SCAN_SKIP_MASK_EN
    // Test 6: skip mask
    begin
      logic [2:0] exp6 [5];
      logic       pd6  [5];
      exp6[0] = 3'd2; exp6[1] = 3'd5; exp6[2] = 3'd7; exp6[3] = 3'd2; exp6[4] = 3'd5;
      pd6[0] = 1'b0; pd6[1] = 1'b0; pd6[2] = 1'b0; pd6[3] = 1'b1; pd6[4] = 1'b0;
      row_mask = 8'b1010_0100; div = 8'd0; single = 1'b0; start = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        start = 1'b0;
        check($sformatf("mask_k%0d", k), exp6[k], 1'b1, pd6[k]);
      end
      go_idle();
      row_mask = 8'h00; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        check($sformatf("mask0_k%0d", k), 3'd0, 1'b0, 1'b0);
      end
      start = 1'b0; row_mask = 8'hFF;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
